// File: rtl/logic_pipe.sv
// Elastic DEPTH-stage pipeline carrying a selectable bitwise op of two operands,
// with valid/ready backpressure, bubble collapsing, 1-cycle bypass, flush and occupancy count.
module logic_pipe #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 2,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       op,
   input  logic             mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] q,
   output logic [CW-1:0]    count
);

   logic [DEPTH-1:0] r_valid;
   logic [WIDTH-1:0] r_data [DEPTH];
   logic [CW-1:0]    r_count;
   logic             r_mode;

   logic [WIDTH-1:0] w_result;
   logic             w_pop;
   logic             w_acc;
   logic             w_go;
   logic [DEPTH-1:0] w_adv;
   logic [DEPTH-1:0] w_shift_in;
   logic [DEPTH-1:0] w_load_in;
   logic [DEPTH-1:0] w_valid_nxt;
   logic [WIDTH-1:0] w_prev [DEPTH];

   always_comb begin
      case (op)
         2'b00:   w_result = a | b;
         2'b01:   w_result = a & b;
         2'b10:   w_result = a ^ b;
         default: w_result = a;
      endcase
   end

   // A stage advances when it holds a beat and its successor is empty or advancing;
   // the chain is resolved from the output end backwards.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      w_pop          = r_valid[DEPTH-1] & out_ready;
      w_go           = w_pop;
      w_adv          = '0;
      w_adv[DEPTH-1] = w_pop;
      for (int i = DEPTH - 2; i >= 0; i--) begin
         w_go     = r_valid[i] & (~r_valid[i+1] | w_go);
         w_adv[i] = w_go;
      end
   end

   always_comb begin
      in_ready    = 1'b0;
      w_load_in   = '0;
      w_shift_in  = '0;
      w_valid_nxt = '0;
      w_prev      = '{default: '0};

      if (!rst && !flush) begin
         if (r_mode) in_ready = ~r_valid[DEPTH-1] | w_pop;
         else        in_ready = ~r_valid[0] | w_adv[0];
      end
      w_acc = in_valid & in_ready;

      // Full mode enters at stage 0, bypass enters at the last stage (same stage when DEPTH=1).
      for (int i = 0; i < DEPTH; i++) begin
         w_load_in[i] = w_acc & (((i == 0) && !r_mode) || ((i == DEPTH - 1) && r_mode));
      end

      w_prev[0] = w_result;
      for (int i = 1; i < DEPTH; i++) begin
         w_shift_in[i] = w_adv[i-1];
         w_prev[i]     = w_load_in[i] ? w_result : r_data[i-1];
      end

      for (int i = 0; i < DEPTH; i++) begin
         w_valid_nxt[i] = (r_valid[i] & ~w_adv[i]) | w_shift_in[i] | w_load_in[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the data stages are reset too, because q=0 after reset is part of the contract.
         r_valid <= '0;
         for (int i = 0; i < DEPTH; i++) r_data[i] <= '0;
         r_count <= '0;
         r_mode  <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so every stage samples pre-edge values.
         r_valid <= flush ? '0 : w_valid_nxt;

         // Flush clears occupancy only; data and q keep their last contents.
         if (!flush) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (w_load_in[i] | w_shift_in[i]) r_data[i] <= w_prev[i];
            end
         end

         if (flush)               r_count <= '0;
         else if (w_acc & ~w_pop) r_count <= r_count + CW'(1);
         else if (~w_acc & w_pop) r_count <= r_count - CW'(1);

         // Mode only switches on an empty, idle pipe so beats always leave in acceptance order.
         if ((r_count == '0) && !w_acc) r_mode <= mode;
      end
   end

   assign q         = r_data[DEPTH-1];
   assign out_valid = r_valid[DEPTH-1];
   assign count     = r_count;

endmodule

// File: tb/tb_logic_pipe.sv
// Scoreboard bench for logic_pipe (WIDTH=8, DEPTH=3): directed beats push hand-computed
// results; an independent monitor pops and compares on every handshaken output.
module tb_logic_pipe;

   localparam int WIDTH = 8;
   localparam int DEPTH = 3;
   localparam int CW    = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             rst;
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [1:0]       op;
   logic             mode;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] q;
   logic [CW-1:0]    count;

   typedef struct {
      logic [WIDTH-1:0] data;
      int               cyc;   // required output cycle, -1 when stalls make it open
   } exp_t;

   exp_t sb[$];
   exp_t m_e;
   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;
   int   waited;

   logic_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .mode      (mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .q         (q),
      .count     (count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Offer one beat until accepted; push its expected result at the accepting cycle.
   task automatic send(input logic [7:0] ta, input logic [7:0] tb_, input logic [1:0] top,
                       input logic [7:0] texp, input int tlat, output int nwait);
      exp_t e;
      a        = ta;
      b        = tb_;
      op       = top;
      in_valid = 1'b1;
      nwait    = 0;
      for (int n = 0; n < 64; n++) begin
         @(negedge clk);
         if (in_ready) begin
            e.data = texp;
            e.cyc  = (tlat < 0) ? -1 : cyc + tlat;
            sb.push_back(e);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            return;
         end
         nwait++;
         @(posedge clk);
         #1;
      end
      checks++;
      errors++;
      $display("FAIL send_timeout: beat %0h never accepted, expected acceptance", texp);
      in_valid = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pop_unexpected: got q=%0h, expected no output", q);
         end else begin
            m_e = sb.pop_front();
            check("pop_q", 32'(q), 32'(m_e.data));
            if (m_e.cyc >= 0) check("pop_cycle", cyc, m_e.cyc);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = '0;
      mode = 1'b0; out_ready = 1'b1;
      tick(2);
      check("rst_in_ready", 32'(in_ready), 0);
      check("rst_q", 32'(q), 0);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_count", 32'(count), 0);
      rst = 1'b0;
      tick(1);

      // Single beat, full mode, latency 3, count 1,1,1,0
      send(8'hA0, 8'h05, 2'b00, 8'hA5, 3, waited);
      check("t1_count_c1", 32'(count), 1);
      tick(1);
      check("t1_count_c2", 32'(count), 1);
      tick(1);
      check("t1_count_c3", 32'(count), 1);
      check("t1_out_valid_c3", 32'(out_valid), 1);
      tick(1);
      check("t1_count_c4", 32'(count), 0);

      // Back-to-back ops, one result per cycle
      send(8'hF0, 8'h3C, 2'b00, 8'hFC, 3, waited);
      send(8'hF0, 8'h3C, 2'b01, 8'h30, 3, waited);
      send(8'hF0, 8'h3C, 2'b10, 8'hCC, 3, waited);
      send(8'hF0, 8'h3C, 2'b11, 8'hF0, 3, waited);
      tick(4);
      check("t2_drained", 32'(count), 0);

      // Backpressure: three fill the pipe, the fourth waits for the first pop
      out_ready = 1'b0;
      send(8'h11, 8'h22, 2'b00, 8'h33, -1, waited);
      send(8'hFF, 8'h0F, 2'b01, 8'h0F, -1, waited);
      send(8'h55, 8'hFF, 2'b10, 8'hAA, -1, waited);
      check("t3_count_full", 32'(count), 3);
      check("t3_q_head", 32'(q), 32'h33);
      a = 8'h81; b = 8'h00; op = 2'b11; in_valid = 1'b1;
      @(negedge clk);
      check("t3_in_ready_full", 32'(in_ready), 0);
      @(posedge clk);
      #1;
      check("t3_q_stable", 32'(q), 32'h33);
      check("t3_valid_stable", 32'(out_valid), 1);
      check("t3_count_stable", 32'(count), 3);
      out_ready = 1'b1;
      send(8'h81, 8'h00, 2'b11, 8'h81, -1, waited);
      check("t3_accept_with_pop", waited, 0);
      tick(5);
      check("t3_drained", 32'(count), 0);

      // Bypass: latency 1; mode change with a beat in flight waits for drain
      mode = 1'b1;
      tick(1);
      send(8'h0F, 8'hF0, 2'b10, 8'hFF, 1, waited);
      check("t4_bypass_valid", 32'(out_valid), 1);
      check("t4_bypass_q", 32'(q), 32'hFF);
      mode = 1'b0;
      send(8'h0F, 8'hFF, 2'b01, 8'h0F, 1, waited);
      check("t4_bypass_stream", waited, 0);
      tick(2);
      send(8'h12, 8'h34, 2'b10, 8'h26, 3, waited);
      tick(4);

      // Flush with two beats in flight and a coincident offered beat
      out_ready = 1'b0;
      send(8'h01, 8'h02, 2'b00, 8'h03, -1, waited);
      send(8'h04, 8'h08, 2'b00, 8'h0C, -1, waited);
      check("t5_count_pre", 32'(count), 2);
      flush = 1'b1; in_valid = 1'b1; a = 8'hEE; b = 8'h00; op = 2'b11;
      @(negedge clk);
      check("t5_flush_in_ready", 32'(in_ready), 0);
      #1 sb.delete();
      @(posedge clk);
      #1;
      flush = 1'b0; in_valid = 1'b0;
      check("t5_count", 32'(count), 0);
      check("t5_out_valid", 32'(out_valid), 0);
      check("t5_q_hold", 32'(q), 32'h26);
      out_ready = 1'b1;
      tick(4);
      check("t5_no_ghost", 32'(out_valid), 0);
      check("t5_count_after", 32'(count), 0);

      // Reset with a full pipe
      out_ready = 1'b0;
      send(8'h11, 8'h22, 2'b00, 8'h33, -1, waited);
      send(8'h44, 8'h0F, 2'b01, 8'h04, -1, waited);
      send(8'h77, 8'h70, 2'b10, 8'h07, -1, waited);
      check("t6_count_full", 32'(count), 3);
      rst = 1'b1;
      @(negedge clk);
      check("t6_rst_in_ready", 32'(in_ready), 0);
      #1 sb.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("t6_q", 32'(q), 0);
      check("t6_count", 32'(count), 0);
      check("t6_out_valid", 32'(out_valid), 0);
      out_ready = 1'b1;
      send(8'hC3, 8'h3C, 2'b00, 8'hFF, 3, waited);
      tick(4);

      // Reset while in bypass: first beat after release must use full-mode latency
      mode = 1'b1;
      tick(1);
      out_ready = 1'b0;
      send(8'h5A, 8'h00, 2'b11, 8'h5A, -1, waited);
      rst = 1'b1;
      @(negedge clk);
      #1 sb.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;
      send(8'h0F, 8'h0F, 2'b10, 8'h00, 3, waited);
      tick(5);
      mode = 1'b0;
      check("scoreboard_empty", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/logic_pipe.md
Name: logic_pipe

Overview:
- Parametrised, elastic register pipeline that applies a selectable bitwise operation to two operand vectors and carries the result through DEPTH registered stages.
- Successor to the single-bit two-register OR stage: generalises width and depth, adds op select, valid/ready backpressure with bubble collapsing, a 1-cycle bypass mode, flush and an occupancy count.
- Sits between operand producers and any registered consumer that needs a fixed-latency or minimum-latency logic result.

Parameters:
- WIDTH, 8, operand/result width in bits (>=1).
- DEPTH, 2, number of pipeline stages (>=1); full-mode latency in cycles.
- CW, $clog2(DEPTH+1), width of occupancy count (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock, sole clock domain.
- rst  in  1  synchronous reset, active high.
- flush  in  1  synchronous pipeline clear; lower priority than rst.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  pipeline accepts beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op  in  2  00=A|B, 01=A&B, 10=A^B, 11=A (pass). Sampled with each accepted beat.
- mode  in  1  0=full (latency DEPTH), 1=bypass (latency 1).
- out_valid  out  1  q holds a valid result.
- out_ready  in  1  consumer accepts q this cycle.
- q  out  WIDTH  result, registered; equals last-stage data register.
- count  out  CW  number of occupied stages, 0..DEPTH.

Behaviour:
- Reset (rst=1 at posedge): all stage valids=0, all stage data=0, q=0, out_valid=0, count=0, mode_q=0. Reset mid-transfer discards all in-flight beats. in_ready=0 while rst is high.
- Accept: a beat is taken when in_valid&in_ready at the posedge; op(a,b) is computed combinationally and registered into stage 0 (full mode) or the last stage (bypass mode).
- Pop: a beat leaves when out_valid&out_ready at the posedge.
- Stage i (i<DEPTH-1) advances into i+1 when i+1 is empty or i+1 is advancing. The last stage advances on pop. Bubbles collapse; no beat is ever dropped or duplicated.
- Full mode in_ready = !valid[0] | stage0 advancing. Bypass mode in_ready = !valid[DEPTH-1] | pop.
- Latency is from accept to out_valid. Full mode: DEPTH cycles with no stall. Bypass mode: 1 cycle. DEPTH=1 makes both modes identical.
- Throughput: 1 beat/cycle sustained when out_ready=1, in both modes, including simultaneous accept and pop on a full pipe.
- Mode: mode_q <= mode only on cycles where count==0 and no accept is occurring. Otherwise mode_q holds, so a mode change with beats in flight takes effect after drain. Beats always exit in acceptance order.
- flush=1 (rst=0): all valids cleared next cycle and count=0; data registers and q hold their values. in_ready=0 during flush, so a coincident in_valid beat is dropped. out_valid stays as registered, so a pop coinciding with flush completes normally.
- count: +1 on accept, -1 on pop, unchanged when both or neither occur. Forced to 0 by rst or flush. Never exceeds DEPTH and never underflows.
- q updates only when the last stage loads; it holds after a pop (stale data is allowed when out_valid=0).
- Output stability: while out_valid=1 and out_ready=0, q and out_valid hold.
- Arithmetic: pure bitwise, WIDTH in, WIDTH out, no carry.

Test Plan:
- WIDTH=8, DEPTH=3, mode=0, out_ready=1: accept a=8'hA0, b=8'h05, op=00 at cycle 0 -> out_valid=1, q=8'hA5 at cycle 3; count goes 1,1,1,0.
- Same config: back-to-back ops OR/AND/XOR/pass on a=8'hF0, b=8'h3C -> q sequence 8'hFC, 8'h30, 8'hCC, 8'hF0 on consecutive cycles 3..6.
- out_ready=0 with 4 beats offered -> 3 accepted, in_ready=0 on the 4th, count=3, q stable. Then out_ready=1 -> 4th accepted the same cycle as the first pop; all 4 results exit in order.
- Set mode=1 with count==0, accept a=8'h0F, b=8'hF0, op=10 -> q=8'hFF, out_valid=1 the next cycle. Toggle mode to 0 with 1 beat in flight -> mode_q stays 1 until drained.
- Fill 2 beats, assert flush together with in_valid -> next cycle count=0, out_valid=0, q unchanged, offered beat not accepted.
- Assert rst mid-stream with DEPTH=3 full -> next cycle q=0, count=0, out_valid=0, mode_q=0. The first beat after rst releases exits with full-mode latency 3.
